// File: rtl/dmem_requester_pkg.sv
// Shared constants for the unified-memory model, the data-side requester and the fetch unit.
package dmem_requester_pkg;

    localparam int LATENCY   = 2;
    localparam int WORD_SIZE = 16;

    localparam logic [WORD_SIZE-1:0] OPCODE_NOP = 16'hF01C;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_requester.sv
// Data-port initiator: one load/store at a time, counts the memory read latency
// and captures the returned word on the cycle the memory actually presents it.
module dmem_requester #(
    parameter int LATENCY   = dmem_requester_pkg::LATENCY,
    parameter int WORD_SIZE = dmem_requester_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 stall,
    output logic                 d_readM,
    output logic                 d_writeM,
    output logic [WORD_SIZE-1:0] d_address,
    inout  wire  [WORD_SIZE-1:0] d_data
);
    import dmem_requester_pkg::*;

    localparam int CNT_W = $clog2(LATENCY + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY + 1);

    state_t               state, state_n;
    logic                 accept;
    logic                 read_done;
    logic [CNT_W-1:0]     cnt;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;

    assign read_done = (state == READ) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_n = req_write ? WRITE : READ;
                end
            end
            READ:    if (cnt == CNT_LAST) state_n = IDLE;
            WRITE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered off next-state so the strobes line up with the state itself.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            stall      <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            d_readM    <= 1'b0;
            d_writeM   <= 1'b0;
            d_address  <= '0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                if (req_write) wdata_q <= req_wdata;
            end
            cnt        <= (state == READ && !read_done) ? cnt + 1'b1 : '0;
            resp_valid <= read_done || (state == WRITE);
            if (read_done) resp_rdata <= d_data;
            req_ready  <= (state_n == IDLE);
            stall      <= (state_n != IDLE);
            d_readM    <= (state_n == READ);
            d_writeM   <= (state_n == WRITE);
            if (state_n == IDLE) d_address <= '0;
            else                 d_address <= accept ? req_addr : addr_q;
        end
    end

    assign d_data = d_writeM ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_dmem_requester.sv
// Directed bench for dmem_requester with a small latency-modelled memory on the data port.
module tb_dmem_requester;

    localparam int LAT = dmem_requester_pkg::LATENCY;
    localparam int W   = dmem_requester_pkg::WORD_SIZE;
    localparam logic [W-1:0] NOP = dmem_requester_pkg::OPCODE_NOP;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_write = 1'b0;
    logic [W-1:0] req_addr = '0;
    logic [W-1:0] req_wdata = '0;
    logic         req_ready, resp_valid, stall, d_readM, d_writeM;
    logic [W-1:0] resp_rdata, d_address;
    wire  [W-1:0] d_data;

    int errors = 0;
    int checks = 0;

    dmem_requester dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .stall(stall), .d_readM(d_readM), .d_writeM(d_writeM),
        .d_address(d_address), .d_data(d_data)
    );

    always #5 clk = ~clk;

    // Memory model: NOP until the (LAT+2)th consecutive read-strobe cycle.
    logic [W-1:0] mem [0:65535];
    int           mcnt = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            mcnt    <= 0;
            mem[1]  <= 16'h0001;
            mem[2]  <= 16'hFFFF;
            mem[35] <= 16'h6000;
        end else begin
            if (d_readM) mcnt <= (mcnt == LAT + 1) ? 0 : mcnt + 1;
            else         mcnt <= 0;
            if (d_writeM) mem[d_address] <= d_data;
        end
    end

    assign d_data = d_readM ? ((mcnt == LAT + 1) ? mem[d_address] : NOP) : {W{1'bz}};

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a load and walk the fixed LAT+3 cycle timeline.
    task automatic do_load(input logic [W-1:0] addr, input logic [W-1:0] exp);
        logic [W-1:0] prev;
        prev      = resp_rdata;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        chk("ld_addr", d_address, addr);
        chk("ld_stall", {15'd0, stall}, 16'd1);
        chk("ld_ready", {15'd0, req_ready}, 16'd0);
        for (int i = 0; i < LAT + 2; i++) begin
            chk("ld_strobe", {15'd0, d_readM}, 16'd1);
            chk("ld_nowrite", {15'd0, d_writeM}, 16'd0);
            chk("ld_noresp", {15'd0, resp_valid}, 16'd0);
            chk("ld_hold", resp_rdata, prev);
            tick();
        end
        chk("ld_resp", {15'd0, resp_valid}, 16'd1);
        chk("ld_data", resp_rdata, exp);
        chk("ld_strobe_off", {15'd0, d_readM}, 16'd0);
        chk("ld_stall_off", {15'd0, stall}, 16'd0);
        chk("ld_addr_idle", d_address, 16'd0);
        tick();
        chk("ld_pulse", {15'd0, resp_valid}, 16'd0);
    endtask

    task automatic do_store(input logic [W-1:0] addr, input logic [W-1:0] data);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        tick();
        req_valid = 1'b0;
        chk("st_strobe", {15'd0, d_writeM}, 16'd1);
        chk("st_noread", {15'd0, d_readM}, 16'd0);
        chk("st_data", d_data, data);
        chk("st_addr", d_address, addr);
        chk("st_stall", {15'd0, stall}, 16'd1);
        chk("st_noresp", {15'd0, resp_valid}, 16'd0);
        tick();
        chk("st_resp", {15'd0, resp_valid}, 16'd1);
        chk("st_strobe_off", {15'd0, d_writeM}, 16'd0);
        chk("st_stall_off", {15'd0, stall}, 16'd0);
        tick();
        chk("st_pulse", {15'd0, resp_valid}, 16'd0);
    endtask

    initial begin
        int nresp;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_ready", {15'd0, req_ready}, 16'd1);
        chk("rst_stall", {15'd0, stall}, 16'd0);
        chk("rst_resp", {15'd0, resp_valid}, 16'd0);
        chk("rst_rdata", resp_rdata, 16'd0);
        chk("rst_read", {15'd0, d_readM}, 16'd0);
        chk("rst_write", {15'd0, d_writeM}, 16'd0);
        chk("rst_addr", d_address, 16'd0);

        do_load(16'h0001, 16'h0001);
        do_load(16'h0002, 16'hFFFF);
        do_load(16'h0023, 16'h6000);
        do_store(16'h0010, 16'h1234);
        do_load(16'h0010, 16'h1234);
        do_load(16'h0023, 16'h6000);

        // Back-to-back: load then store with req_valid held high throughout.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0001;
        tick();
        req_write = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'hBEEF;
        for (int i = 0; i < LAT + 2; i++) begin
            chk("b2b_busy_read", {15'd0, d_readM}, 16'd1);
            chk("b2b_busy_addr", d_address, 16'h0001);
            tick();
        end
        chk("b2b_resp1", {15'd0, resp_valid}, 16'd1);
        chk("b2b_ready1", {15'd0, req_ready}, 16'd1);
        chk("b2b_data1", resp_rdata, 16'h0001);
        tick();
        req_valid = 1'b0;
        chk("b2b_write", {15'd0, d_writeM}, 16'd1);
        chk("b2b_waddr", d_address, 16'h0020);
        chk("b2b_wdata", d_data, 16'hBEEF);
        chk("b2b_resp_gap", {15'd0, resp_valid}, 16'd0);
        tick();
        chk("b2b_resp2", {15'd0, resp_valid}, 16'd1);
        tick();
        do_load(16'h0020, 16'hBEEF);

        // Request pulsed while busy: ignored, one response only.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0002;
        tick();
        req_valid = 1'b0;
        tick();
        req_valid = 1'b1;
        req_addr  = 16'h0023;
        tick();
        req_valid = 1'b0;
        chk("busy_addr_kept", d_address, 16'h0002);
        nresp = 0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid) nresp++;
            tick();
        end
        chk("busy_one_resp", 16'(nresp), 16'd1);
        chk("busy_data", resp_rdata, 16'hFFFF);
        chk("busy_idle", {15'd0, req_ready}, 16'd1);

        // Reset during the second READ cycle abandons the load.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0023;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_read", {15'd0, d_readM}, 16'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mrst_read", {15'd0, d_readM}, 16'd0);
        chk("mrst_ready", {15'd0, req_ready}, 16'd1);
        chk("mrst_stall", {15'd0, stall}, 16'd0);
        chk("mrst_rdata", resp_rdata, 16'd0);
        chk("mrst_addr", d_address, 16'd0);
        nresp = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) nresp++;
            tick();
        end
        chk("mrst_no_resp", 16'(nresp), 16'd0);
        do_load(16'h0001, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_requester.md
# dmem_requester

CPU-side initiator for the data port of the latency-modelled unified memory. It accepts one load or store at a time from the pipeline's MEM stage and drives `d_readM`/`d_writeM`/`d_address`/`d_data`. Because the memory returns a NOP word until its data is ready, the block counts the read latency itself and captures the word on the correct cycle. It then returns the word to the pipeline with a one-cycle valid pulse and a stall indication.

## Interface
- `LATENCY`, default 2: memory latency constant; a data read completes after `LATENCY+2` cycles of `d_readM`.
- `WORD_SIZE`, default 16: data and address width.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  pipeline request present.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  WORD_SIZE  word address.
- `req_wdata`  in  WORD_SIZE  store data.
- `req_ready`  out  1  block idle; a request is accepted at the rising edge where `req_valid && req_ready`.
- `resp_valid`  out  1  one-cycle pulse: load data valid, or store complete.
- `resp_rdata`  out  WORD_SIZE  captured load data; holds its value until the next load completes.
- `stall`  out  1  high while a request is outstanding (state ≠ IDLE).
- `d_readM`  out  1  memory read strobe.
- `d_writeM`  out  1  memory write strobe.
- `d_address`  out  WORD_SIZE  memory address.
- `d_data`  inout  WORD_SIZE  driven with write data only while `d_writeM`=1; high-Z otherwise.

## Operation
- FSM states: IDLE, READ, WRITE.
- IDLE: `req_ready`=1 and both strobes are 0.
  - Accepting a load latches the address and moves to READ with counter=0.
  - Accepting a store latches the address and data and moves to WRITE.
- READ:
  - `d_readM`=1 and `d_address` = the latched address.
  - The counter increments each cycle.
  - When counter == `LATENCY+1`, `d_data` is sampled into `resp_rdata` at that edge, the FSM returns to IDLE, and `resp_valid` is asserted for the following cycle.
- WRITE:
  - Lasts exactly one cycle with `d_writeM`=1 and `d_data` = the latched write data.
  - Returns to IDLE; `resp_valid` is asserted for the following cycle.
- `resp_valid` and `req_ready` may both be 1 in the same cycle. A new request is accepted in the cycle its predecessor's response is delivered, which gives zero bubble between transactions.
- `req_valid` while `req_ready`=0 is ignored. The pipeline holds the request; the block does not queue it.
- `d_readM` and `d_writeM` are never asserted together.
- `d_address` = 0 when idle.
- Counter width is `$clog2(LATENCY+2)` bits. It never wraps because it is cleared on entry to READ.
- Reset values: state=IDLE, `req_ready`=1, `stall`=0, `resp_valid`=0, `resp_rdata`=0, `d_readM`=0, `d_writeM`=0, `d_address`=0, `d_data`=Z, counter=0.
- Reset asserted mid-READ or mid-WRITE:
  - Abandons the transaction at that edge with no `resp_valid`.
  - The memory's own counter is cleared by the same synchronous reset, so the two stay aligned.

## Timing
- All outputs are registered; nothing combinational runs from `req_*` to `d_*`.
- Load accepted at edge T:
  - `d_readM`=1 in cycles T+1 … T+LATENCY+2.
  - Capture happens at the edge ending cycle T+LATENCY+2.
  - `resp_valid` is high in cycle T+LATENCY+3.
  - With LATENCY=2: 4 strobe cycles, response in cycle 5.
- Store accepted at edge T:
  - `d_writeM`=1 in cycle T+1; memory is updated at the edge ending T+1.
  - `resp_valid` is high in cycle T+2.
- Load latency is fixed at LATENCY+3 cycles from acceptance to response. Store latency is fixed at 2.
- `stall` = 1 from cycle T+1 until the cycle before `resp_valid`.

## Structure
- The shared constants package holds `LATENCY`, `WORD_SIZE`, the `OPCODE_NOP` value and the 2-bit state encoding (IDLE=0, READ=1, WRITE=2). It is shared with the memory model and the instruction-side fetch unit.
- Single module with no sub-module. The tristate driver is one continuous assign on `d_data`.

## Test plan
- Reset, then load addr 0x0001: `d_readM` is high for exactly 4 cycles, `resp_valid` pulses in cycle 5, and `resp_rdata`=0x0001. The NOP word seen on `d_data` during cycles 1–3 is never captured.
- Load 0x0002 → `resp_rdata`=0xFFFF. Load 0x0023 → `resp_rdata`=0x6000.
- Store 0x1234 to 0x0010, then load 0x0010:
  - The store shows `d_writeM` for 1 cycle with `d_data`=0x1234 and `resp_valid` in cycle 2.
  - The load returns 0x1234.
  - `d_data` is Z in every non-write cycle.
- Back-to-back: `req_valid` held high with load 0x01 then store to 0x20. The second request is accepted in the cycle the first response is delivered, with no idle cycle between.
- `req_valid` pulsed while `stall`=1: no acceptance, no change to the latched address, and exactly one response.
- `reset_n` low for 1 cycle during the 2nd READ cycle: all outputs return to reset values next cycle with no `resp_valid`. A following load of 0x0001 returns 0x0001 with normal latency.
